// File: rtl/ntt_pkg.sv
// Shared constants, coefficient type and Z_3329 arithmetic for the 8-point NTT/INTT datapath.
package ntt_pkg;

  localparam int unsigned N = 8;

  typedef logic [11:0] coeff_t;

  localparam coeff_t Q     = 12'd3329;
  localparam coeff_t N_INV = 12'd2913;
  localparam coeff_t W     = 12'd2580;

  // w^0..w^7 with w = 17^32 mod Q; w^4 = Q-1, so w^-e = w^(8-e).
  localparam coeff_t TWIDDLE [8] = '{12'd1, 12'd2580, 12'd1729, 12'd3289,
                                     12'd3328, 12'd749, 12'd1600, 12'd40};

  // Exponent of the twiddle for split k (1 = first stage, 2..3 second, 4..7 third).
  localparam int unsigned TW_EXP [8] = '{0, 0, 0, 2, 0, 2, 1, 3};

  typedef enum logic {BF_CT, BF_GS} bf_mode_e;

  function automatic coeff_t tw_fwd(input logic [2:0] k);
    return TWIDDLE[3'(TW_EXP[k])];
  endfunction

  function automatic coeff_t tw_inv(input logic [2:0] k);
    return TWIDDLE[3'(N - TW_EXP[k])];
  endfunction

  function automatic coeff_t mod_reduce(input coeff_t a);
    return (a >= Q) ? a - Q : a;
  endfunction

  function automatic coeff_t mod_add(input coeff_t a, input coeff_t b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[11:0];
  endfunction

  function automatic coeff_t mod_sub(input coeff_t a, input coeff_t b);
    logic [12:0] d;
    d = {1'b0, a} + {1'b0, Q} - {1'b0, b};
    if (d >= {1'b0, Q}) d = d - {1'b0, Q};
    return d[11:0];
  endfunction

  function automatic coeff_t mod_mul(input coeff_t a, input coeff_t b);
    logic [23:0] p;
    p = a * b;
    return 12'(p % 24'(Q));
  endfunction

endpackage

// File: rtl/ntt_butterfly.sv
// Combinational radix-2 butterfly: Cooley-Tukey (a + tw*b, a - tw*b) or Gentleman-Sande (a + b, (a - b)*tw).
module ntt_butterfly
  import ntt_pkg::*;
(
  input  bf_mode_e    mode,
  input  logic [11:0] a,
  input  logic [11:0] b,
  input  logic [11:0] tw,
  output logic [11:0] x,
  output logic [11:0] y
);

  coeff_t t;

  always_comb begin
    t = '0;
    x = '0;
    y = '0;
    if (mode == BF_CT) begin
      t = mod_mul(b, tw);
      x = mod_add(a, t);
      y = mod_sub(a, t);
    end else begin
      t = mod_sub(a, b);
      x = mod_add(a, b);
      y = mod_mul(t, tw);
    end
  end

endmodule

// File: rtl/full_ntt_intt.sv
// 8-point forward NTT immediately followed by the inverse NTT mod 3329, one vector per cycle,
// eight register stages: reduce, 3x CT, 3x GS, scale by N^-1.
module full_ntt_intt
  import ntt_pkg::*;
(
  input  logic        clk,
  input  logic        r,
  input  logic        valid_in,
  input  logic [11:0] coeffs [7:0],
  output logic        valid_out,
  output logic [11:0] coeffs_out [7:0]
);

  localparam int unsigned STAGES = 8;

  logic [STAGES-1:0] valid_q;
  coeff_t            pipe_q [STAGES][N];
  coeff_t            bf_out [6][N];

  // Inverse stage st undoes forward level 5-st, reusing the same pair layout with inverted twiddles;
  // each GS butterfly yields 2x the original pair, removed by the final N^-1 scaling.
  for (genvar st = 0; st < 6; st++) begin : g_stage
    localparam int unsigned LVL  = (st < 3) ? st : 5 - st;
    localparam int unsigned HALF = 4 >> LVL;
    localparam bf_mode_e    MODE = (st < 3) ? BF_CT : BF_GS;
    for (genvar p = 0; p < 4; p++) begin : g_bf
      localparam int unsigned BLK = p / HALF;
      localparam int unsigned I0  = BLK * 2 * HALF + p % HALF;
      localparam int unsigned I1  = I0 + HALF;
      localparam logic [2:0]  K   = 3'((1 << LVL) + BLK);
      localparam coeff_t      TW  = (st < 3) ? tw_fwd(K) : tw_inv(K);
      ntt_butterfly u_bf (
        .mode (MODE),
        .a    (pipe_q[st][I0]),
        .b    (pipe_q[st][I1]),
        .tw   (TW),
        .x    (bf_out[st][I0]),
        .y    (bf_out[st][I1])
      );
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      valid_q <= '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        for (int unsigned i = 0; i < N; i++) begin
          pipe_q[s][i] <= '0;
        end
      end
    end else begin
      valid_q <= {valid_q[STAGES-2:0], valid_in};
      for (int unsigned i = 0; i < N; i++) begin
        pipe_q[0][i] <= mod_reduce(coeffs[i]);
        for (int unsigned s = 1; s < 7; s++) begin
          pipe_q[s][i] <= bf_out[s-1][i];
        end
        pipe_q[7][i] <= mod_mul(pipe_q[6][i], N_INV);
      end
    end
  end

  always_comb begin
    valid_out = valid_q[STAGES-1];
    for (int unsigned i = 0; i < N; i++) begin
      coeffs_out[i] = pipe_q[STAGES-1][i];
    end
  end

endmodule

// File: tb/tb_full_ntt_intt.sv
// Round-trip bench: every accepted vector must reappear reduced mod 3329 exactly 8 edges later.
module tb_full_ntt_intt;

  logic        clk;
  logic        r;
  logic        valid_in;
  logic [11:0] coeffs [7:0];
  logic        valid_out;
  logic [11:0] coeffs_out [7:0];

  full_ntt_intt dut (
    .clk        (clk),
    .r          (r),
    .valid_in   (valid_in),
    .coeffs     (coeffs),
    .valid_out  (valid_out),
    .coeffs_out (coeffs_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [95:0] vec;
  } exp_t;

  exp_t        q [$];
  int unsigned cyc   = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  function automatic logic [95:0] pack(input logic [11:0] v [7:0]);
    logic [95:0] p;
    for (int i = 0; i < 8; i++) p[i*12 +: 12] = v[i];
    return p;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp_v);
    n_vec++;
    assert (obs === exp_v)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
  endtask

  task automatic set_rand();
    for (int i = 0; i < 8; i++) coeffs[i] = 12'($urandom_range(0, 4095));
  endtask

  task automatic set_all(input int unsigned v);
    for (int i = 0; i < 8; i++) coeffs[i] = 12'(v);
  endtask

  // One clock edge: update the reference queue with what was sampled, then check outputs.
  task automatic tick(input string tag);
    exp_t        e;
    logic [95:0] red;
    bit          ev;
    @(posedge clk);
    cyc++;
    if (!r) begin
      q.delete();
    end else if (valid_in) begin
      for (int i = 0; i < 8; i++) red[i*12 +: 12] = 12'(int'(coeffs[i]) % 3329);
      q.push_back('{due: cyc + 7, vec: red});
    end
    #1;
    if (!r) begin
      chk({tag, "/rst_valid"}, 96'(valid_out), '0);
      chk({tag, "/rst_data"}, pack(coeffs_out), '0);
    end else begin
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk({tag, "/valid"}, 96'(valid_out), 96'(ev));
      if (ev) begin
        e = q.pop_front();
        chk({tag, "/data"}, pack(coeffs_out), e.vec);
      end
    end
  endtask

  initial begin
    r        = 1'b0;
    valid_in = 1'b1;
    set_rand();

    // Reset held with valid_in high.
    tick("reset");
    tick("reset");

    // First vector after release, then the counting vector, then idle.
    r = 1'b1;
    set_rand();
    tick("first");
    for (int i = 0; i < 8; i++) coeffs[i] = 12'(i);
    tick("single");
    valid_in = 1'b0;
    for (int k = 0; k < 10; k++) tick("single_drain");

    // Back-to-back stream, all coefficients equal per vector.
    valid_in = 1'b1;
    for (int k = 0; k < 100; k++) begin
      set_all(3328 - k);
      tick("b2b");
    end
    valid_in = 1'b0;
    for (int k = 0; k < 9; k++) tick("b2b_drain");

    // Out-of-range inputs must come back reduced.
    valid_in  = 1'b1;
    set_all(0);
    coeffs[0] = 12'd3329;
    coeffs[1] = 12'd4095;
    coeffs[2] = 12'd3330;
    tick("oor");
    valid_in = 1'b0;
    for (int k = 0; k < 9; k++) tick("oor_drain");

    // Random vectors with valid toggling every other cycle.
    for (int k = 0; k < 40; k++) begin
      valid_in = (k % 2 == 0);
      set_rand();
      tick("rand");
    end
    valid_in = 1'b0;
    for (int k = 0; k < 9; k++) tick("rand_drain");

    // Asynchronous reset with four vectors in flight.
    valid_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_rand();
      tick("inflight");
    end
    r = 1'b0;
    #1;
    chk("async_rst_valid", 96'(valid_out), '0);
    chk("async_rst_data", pack(coeffs_out), '0);
    q.delete();
    tick("mid_reset");
    tick("mid_reset");
    r = 1'b1;
    set_rand();
    tick("post_reset");
    valid_in = 1'b0;
    for (int k = 0; k < 10; k++) tick("post_drain");

    chk("queue_empty", 96'(q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/full_ntt_intt.md
Name: full_ntt_intt

Overview:
Fully pipelined 8-point forward NTT followed immediately by the 8-point inverse NTT over Z_q, q = 3329 (Kyber modulus). Output is the input vector reduced mod q, after a fixed latency. It is the round-trip self-check datapath for the NTT controller: it proves butterfly, twiddle and scaling logic are mutually consistent.

Parameters:
Q, 3329, modulus; fixed, kept as a package constant.
N, 8, coefficients per vector; fixed.
LATENCY, 8, cycles from a sampled valid_in to the matching valid_out; informational, must equal pipeline depth.

Ports:
clk  in  1  rising-edge clock.
r  in  1  reset, asynchronous, active-low.
valid_in  in  1  input vector valid this cycle.
coeffs  in  8x12 (unpacked [7:0] of [11:0])  input coefficients, index 0 = x0.
valid_out  out  1  coeffs_out holds a result this cycle.
coeffs_out  out  8x12 (unpacked [7:0] of [11:0])  round-trip coefficients, each in [0, Q-1].

Behaviour:
- Reset (r low, async): all valid pipeline bits 0; valid_out = 0; coeffs_out = 0. Data registers may also clear to 0. Reset mid-stream discards in-flight vectors, with no output for them.
- Throughput: one vector per cycle; no backpressure; no stall.
- Pipeline, one register per step:
  - S0 input register: each coefficient reduced mod Q (if >= Q, subtract Q; 12-bit max 4095 < 2Q).
  - S1..S3 forward radix-2 Cooley-Tukey stages, cyclic NTT: X_k = sum_j x_j * w^(j*k) mod Q, with w = 17^32 mod Q = 2580 (primitive 8th root).
  - S4..S6 inverse Gentleman-Sande stages using w^-1 = w^7 mod Q.
  - S7 scaling by N^-1 = 2913 mod Q; drives coeffs_out.
- Latency: vector sampled with valid_in=1 at edge t appears on coeffs_out with valid_out=1 after edge t+7, i.e. 8 register stages.
- valid shifts through an 8-bit pipeline in parallel with data. Data also advances when valid is 0.
- coeffs_out while valid_out=0: don't-care. Hold the last pipeline contents and do not gate them.
- Arithmetic: all intermediates kept in [0, Q-1].
  - Mod add: a+b, subtract Q if >= Q.
  - Mod sub: a-b, add Q if negative.
  - Mod mul: 24-bit product reduced mod Q (Barrett or direct %), combinational within the stage.
- Required invariant: coeffs_out[i] == coeffs[i] mod Q for every accepted vector, in order.

Decomposition:
- Package ntt_pkg: Q, N, N_INV=2913, W=2580, forward/inverse twiddle table (w^0..w^7), coefficient typedef logic [11:0], mod_add/mod_sub/mod_mul functions.
- One sub-module ntt_butterfly with a mode input (CT forward / GS inverse), operands a, b and twiddle; combinational, instantiated 4x per stage, 24x total.
- Top holds the stage registers and the valid shift register.

Test Plan:
- Reset: hold r=0 for 2 cycles with valid_in=1 -> valid_out=0, coeffs_out=0 throughout. Release -> first valid_out exactly 8 cycles after first sampled valid_in.
- Single vector {0,1,2,3,4,5,6,7}, then valid_in=0 -> exactly one valid_out pulse 8 cycles later carrying {0,1,2,3,4,5,6,7}.
- Back-to-back: 100 consecutive vectors, all coefficients = 3328 down to 3229, one per cycle -> 100 consecutive valid_out cycles, outputs identical and in order.
- Out-of-range input: {3329, 4095, 3330, 0, 0, 0, 0, 0} -> {0, 766, 1, 0, 0, 0, 0, 0}.
- Random CSV vectors with valid_in toggling every other cycle -> each output matches its input delayed 8 cycles; valid_out pattern equals valid_in delayed 8. Error count 0.
- Reset asserted with 4 vectors in flight -> no valid_out for them. Next vector after release emerges correctly at latency 8.
